// File: rtl/mollusc_pkg.sv
`default_nettype none
// ============================================================================
// Module : mollusc_pkg
// Purpose: Shared encodings for the mollusc pipeline memory stage: execute
//          op codes, access-size codes and the mem_stage state enum.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package mollusc_pkg;

  // Execute op codes carried on ex_op. 2'b11 is reserved and handled as ALU.
  localparam logic [1:0] OP_ALU   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  // Access size codes carried on ex_size. 2'b11 is unused and handled as word.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } mem_state_e;

  // True when an access of the given size cannot be served at this offset.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    logic r;
    r = 1'b0;
    case (size)
      SZ_BYTE: r = 1'b0;
      SZ_HALF: r = off[0];
      default: r = (off != 2'b00);
    endcase
    return r;
  endfunction

endpackage : mollusc_pkg
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module : mem_lane_align
// Purpose: Combinational byte-lane logic for the memory stage.
//          Store side: byte enables and lane-replicated write data.
//          Load side : lane selection from the raw bus word plus zero/sign
//                      extension to the full register width.
// Ports  : st_size/st_off/st_data  -> st_be, st_wdata
//          ld_size/ld_signed/ld_off/ld_raw -> ld_data
// Rev    : 1.0  initial release
// ============================================================================
module mem_lane_align
  import mollusc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      st_size,
  input  logic [1:0]      st_off,
  input  logic [XLEN-1:0] st_data,
  output logic [3:0]      st_be,
  output logic [XLEN-1:0] st_wdata,
  input  logic [1:0]      ld_size,
  input  logic            ld_signed,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] ld_raw,
  output logic [XLEN-1:0] ld_data
);

  logic [XLEN-1:0] w_ld_shifted;
  logic            w_ld_sign;

  // Store path: the bus picks the lane via byte enables, so the data is
  // simply replicated across every lane the size could land in.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_size)
      SZ_BYTE: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        st_be    = 4'b0011 << st_off;
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = st_data;
      end
    endcase
  end

  // Load path: bring the addressed lane down to bit 0, then extend.
  assign w_ld_shifted = ld_raw >> {ld_off, 3'b000};

  always_comb begin
    w_ld_sign = 1'b0;
    ld_data   = ld_raw;
    case (ld_size)
      SZ_BYTE: begin
        w_ld_sign = ld_signed & w_ld_shifted[7];
        ld_data   = {{(XLEN-8){w_ld_sign}}, w_ld_shifted[7:0]};
      end
      SZ_HALF: begin
        w_ld_sign = ld_signed & w_ld_shifted[15];
        ld_data   = {{(XLEN-16){w_ld_sign}}, w_ld_shifted[15:0]};
      end
      default: begin
        w_ld_sign = 1'b0;
        ld_data   = ld_raw;
      end
    endcase
  end

endmodule : mem_lane_align
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module : mem_stage
// Purpose: Memory-access pipeline stage between execute and writeback.
//          ALU results pass straight to the writeback port; loads and stores
//          run one data-bus transaction with byte-lane alignment. Execute is
//          stalled (ex_ready low) while a transaction is outstanding.
// Ports  : ex_*        instruction handshake from execute
//          mem_req_*   bus request (registered, stable until accepted)
//          mem_resp_*  load response from the bus
//          wb_addr/wb_data  one-cycle registered writeback (addr 0 = none)
//          misaligned  one-cycle pulse when an access is rejected
// Rev    : 1.0  initial release
// ============================================================================
module mem_stage
  import mollusc_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [1:0]        ex_op,
  input  logic [1:0]        ex_size,
  input  logic              ex_signed,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic [XLEN-1:0]   ex_result,
  input  logic [XLEN-1:0]   ex_store_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic              mem_req_we,
  output logic [3:0]        mem_req_be,
  output logic [XLEN-1:0]   mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_data,
  output logic [REG_AW-1:0] wb_addr,
  output logic [XLEN-1:0]   wb_data,
  output logic              misaligned
);

  mem_state_e        r_state;
  logic [1:0]        r_op;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [REG_AW-1:0] r_dest;
  logic [1:0]        r_off;

  logic              r_req_valid;
  logic [XLEN-1:0]   r_req_addr;
  logic              r_req_we;
  logic [3:0]        r_req_be;
  logic [XLEN-1:0]   r_req_wdata;
  logic [REG_AW-1:0] r_wb_addr;
  logic [XLEN-1:0]   r_wb_data;
  logic              r_misaligned;

  logic              w_is_load;
  logic              w_is_store;
  logic              w_misaligned;
  logic [3:0]        w_st_be;
  logic [XLEN-1:0]   w_st_wdata;
  logic [XLEN-1:0]   w_ld_data;

  assign w_is_load    = (ex_op == OP_LOAD);
  assign w_is_store   = (ex_op == OP_STORE);
  assign w_misaligned = is_misaligned(ex_size, ex_result[1:0]);

  // Store lanes are computed from the live execute fields at accept time;
  // load extraction uses the fields latched when the load was accepted.
  mem_lane_align #(
    .XLEN (XLEN)
  ) u_lane_align (
    .st_size   (ex_size),
    .st_off    (ex_result[1:0]),
    .st_data   (ex_store_data),
    .st_be     (w_st_be),
    .st_wdata  (w_st_wdata),
    .ld_size   (r_size),
    .ld_signed (r_signed),
    .ld_off    (r_off),
    .ld_raw    (mem_resp_data),
    .ld_data   (w_ld_data)
  );

  assign ex_ready      = (r_state == ST_IDLE);
  assign mem_req_valid = r_req_valid;
  assign mem_req_addr  = r_req_addr;
  assign mem_req_we    = r_req_we;
  assign mem_req_be    = r_req_be;
  assign mem_req_wdata = r_req_wdata;
  assign wb_addr       = r_wb_addr;
  assign wb_data       = r_wb_data;
  assign misaligned    = r_misaligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_op         <= OP_ALU;
      r_size       <= SZ_BYTE;
      r_signed     <= 1'b0;
      r_dest       <= '0;
      r_off        <= 2'b00;
      r_req_valid  <= 1'b0;
      r_req_addr   <= '0;
      r_req_we     <= 1'b0;
      r_req_be     <= 4'b0000;
      r_req_wdata  <= '0;
      r_wb_addr    <= '0;
      r_wb_data    <= '0;
      r_misaligned <= 1'b0;
    end else begin
      // Writeback and the misaligned flag are single-cycle pulses.
      r_wb_addr    <= '0;
      r_wb_data    <= '0;
      r_misaligned <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (ex_valid) begin
            if (w_is_load || w_is_store) begin
              if (w_misaligned) begin
                r_misaligned <= 1'b1;
              end else begin
                r_op        <= ex_op;
                r_size      <= ex_size;
                r_signed    <= ex_signed;
                r_dest      <= ex_dest;
                r_off       <= ex_result[1:0];
                r_req_valid <= 1'b1;
                r_req_addr  <= {ex_result[XLEN-1:2], 2'b00};
                r_req_we    <= w_is_store;
                // Reads carry no byte enables; the full word comes back.
                r_req_be    <= w_is_store ? w_st_be : 4'b0000;
                r_req_wdata <= w_is_store ? w_st_wdata : '0;
                r_state     <= ST_REQ;
              end
            end else begin
              // ALU and the reserved op code both write the result back.
              r_wb_addr <= ex_dest;
              r_wb_data <= (ex_dest != '0) ? ex_result : '0;
            end
          end
        end

        ST_REQ: begin
          if (mem_req_ready) begin
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_req_we    <= 1'b0;
            r_req_be    <= 4'b0000;
            r_req_wdata <= '0;
            // Stores retire at the handshake; no response is expected.
            r_state     <= (r_op == OP_STORE) ? ST_IDLE : ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (mem_resp_valid) begin
            r_wb_addr <= r_dest;
            r_wb_data <= (r_dest != '0) ? w_ld_data : '0;
            r_state   <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : mem_stage
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between execute and register writeback. Accepts one instruction per handshake from execute (ALU pass-through, load, or store), performs the data-bus transaction with byte-lane alignment and sign extension, and drives the register file's writeback port (`write_addr`/`write_data`) with a registered one-cycle write. Stalls execute via `ex_ready` while a bus transaction is outstanding.

## Interface
- `REG_AW`, 4, register address width; address 0 is the hardwired zero register.
- `XLEN`, 32, data and address width.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ex_valid`  in  1  execute presents an instruction.
- `ex_ready`  out  1  stage accepts; high only in IDLE.
- `ex_op`  in  2  00 ALU, 01 LOAD, 10 STORE, 11 reserved (treated as ALU).
- `ex_size`  in  2  00 byte, 01 half, 10 word.
- `ex_signed`  in  1  sign-extend loads.
- `ex_dest`  in  REG_AW  destination register.
- `ex_result`  in  XLEN  ALU result, or effective address for LOAD/STORE.
- `ex_store_data`  in  XLEN  store value, right-aligned.
- `mem_req_valid`  out  1  bus request.
- `mem_req_ready`  in  1  bus accepts request.
- `mem_req_addr`  out  XLEN  word-aligned address (`addr[1:0]`=0).
- `mem_req_we`  out  1  1 for store.
- `mem_req_be`  out  4  byte enables.
- `mem_req_wdata`  out  XLEN  lane-replicated store data.
- `mem_resp_valid`  in  1  load data returned.
- `mem_resp_data`  in  XLEN  raw word.
- `wb_addr`  out  REG_AW  writeback address; 0 = no write.
- `wb_data`  out  XLEN  writeback data.
- `misaligned`  out  1  one-cycle pulse on misaligned access.

## Operation
- States: IDLE, REQ, WAIT.
- IDLE, accept (`ex_valid & ex_ready`):
  - ALU: next cycle `wb_addr=ex_dest`, `wb_data=ex_result`; stay IDLE.
  - LOAD/STORE aligned: latch op, size, signed, dest, `addr[1:0]`, store data; go REQ.
  - Misaligned (half with `addr[0]`=1, word with `addr[1:0]`!=0): no bus access; next cycle `misaligned=1`, `wb_addr=0`; stay IDLE.
- REQ: `mem_req_valid=1`, request fields stable until `mem_req_ready`. On handshake: LOAD -> WAIT; STORE -> IDLE (stores complete at handshake, no response).
- WAIT: on `mem_resp_valid`, select lane by latched `addr[1:0]`, zero/sign extend per size/signed; next cycle `wb_addr=dest`, `wb_data=extended`; go IDLE.
- Byte enables: byte `4'b0001<<a[1:0]`; half `4'b0011<<a[1:0]`; word `4'b1111`. wdata: byte replicated x4, half x2, word as-is.
- `ex_dest`=0 always yields `wb_addr=0`.
- `mem_resp_valid` outside WAIT is ignored; `mem_req_ready` outside REQ is ignored.
- When no write occurs in a cycle, `wb_addr=0` and `wb_data` is don't-care (drive 0).

## Timing
- Reset: state IDLE; `ex_ready=1`; `mem_req_valid=0`, `mem_req_we=0`, `mem_req_be=0`, `mem_req_addr=0`, `mem_req_wdata=0`; `wb_addr=0`, `wb_data=0`; `misaligned=0`.
- ALU: accepted at T, `wb_*` valid at T+1 for exactly one cycle; back-to-back ALU ops at 1/cycle.
- LOAD: accepted T; `mem_req_valid` from T+1; handshake at H>=T+1; WAIT from H+1; response at R>=H+1; `wb_*` at R+1; `ex_ready` high again at R+1. Minimum latency 3 cycles.
- STORE: accepted T; handshake at H>=T+1; `ex_ready` high at H+1.
- `ex_ready` is a combinational function of state only.
- Reset mid-transaction abandons it: `mem_req_valid` low the cycle after `rst`; late responses are ignored in IDLE; no writeback issued.

## Structure
- Shared package `mollusc_pkg`: op codes (`OP_ALU`, `OP_LOAD`, `OP_STORE`), size codes (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`), state enum for this stage.
- One sub-module `mem_lane_align`: combinational byte-enable/wdata generation and load extraction/extension, from size, signed, and `addr[1:0]`.

## Test plan
- ALU `ex_dest=3`, `ex_result=0xDEADBEEF` -> next cycle `wb_addr=3`, `wb_data=0xDEADBEEF`; then `wb_addr=0`.
- Signed byte load at `0x1003`, `mem_req_ready` delayed 2 cycles, response `0x80FFFFFF` -> `mem_req_addr=0x1000`, `be=0000` (read), `wb_data=0xFFFFFF80`; unsigned variant -> `0x00000080`.
- Half store `0xABCD` at `0x2002` -> `mem_req_be=1100`, `wdata=0xABCDABCD`, `we=1`; `ex_ready` high the cycle after handshake, no writeback.
- Word load at `0x3001` -> `misaligned` pulse, no `mem_req_valid`, `wb_addr=0`.
- Load accepted, `rst` asserted in WAIT, response arrives 1 cycle later -> state IDLE, `wb_addr` stays 0.
- Load to `ex_dest=0`, response `0x12345678` -> `wb_addr=0`; spurious `mem_resp_valid` in IDLE -> no effect.
